// File: rtl/fp_divsqrt_issue_ctrl_if.sv
// Request / unit / result signal bundle for the divide-sqrt issue controller.
// slave is the controller's view, master is the surrounding pipeline's view.
interface fp_divsqrt_issue_ctrl_if #(
  parameter int unsigned FP_WIDTH   = 32,
  parameter int unsigned TAG_WIDTH  = 5,
  parameter int unsigned RND_WIDTH  = 3,
  parameter int unsigned STAT_WIDTH = 5,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [FP_WIDTH-1:0]   req_opa_i;
  logic [FP_WIDTH-1:0]   req_opb_i;
  logic                  req_sqrt_i;
  logic [TAG_WIDTH-1:0]  req_tag_i;
  logic [RND_WIDTH-1:0]  req_rnd_i;

  logic                  unit_en_o;
  logic                  unit_ready_i;
  logic [FP_WIDTH-1:0]   unit_opa_o;
  logic [FP_WIDTH-1:0]   unit_opb_o;
  logic                  unit_sqrt_o;
  logic [TAG_WIDTH-1:0]  unit_tag_o;
  logic [RND_WIDTH-1:0]  unit_rnd_o;
  logic                  unit_valid_i;
  logic [FP_WIDTH-1:0]   unit_res_i;
  logic [STAT_WIDTH-1:0] unit_status_i;

  logic                  res_valid_o;
  logic                  res_ready_i;
  logic [FP_WIDTH-1:0]   res_o;
  logic [STAT_WIDTH-1:0] res_status_o;
  logic [TAG_WIDTH-1:0]  res_tag_o;

  logic                  busy_o;
  logic [CNT_W-1:0]      count_o;

  modport slave (
    input  req_valid_i, req_opa_i, req_opb_i, req_sqrt_i, req_tag_i, req_rnd_i,
    output req_ready_o,
    output unit_en_o, unit_opa_o, unit_opb_o, unit_sqrt_o, unit_tag_o, unit_rnd_o,
    input  unit_ready_i, unit_valid_i, unit_res_i, unit_status_i,
    output res_valid_o, res_o, res_status_o, res_tag_o,
    input  res_ready_i,
    output busy_o, count_o
  );

  modport master (
    output req_valid_i, req_opa_i, req_opb_i, req_sqrt_i, req_tag_i, req_rnd_i,
    input  req_ready_o,
    input  unit_en_o, unit_opa_o, unit_opb_o, unit_sqrt_o, unit_tag_o, unit_rnd_o,
    output unit_ready_i, unit_valid_i, unit_res_i, unit_status_i,
    input  res_valid_o, res_o, res_status_o, res_tag_o,
    output res_ready_i,
    input  busy_o, count_o
  );
endinterface

// File: rtl/fp_divsqrt_issue_ctrl.sv
// Queues divide/sqrt requests, issues them one at a time to an iterative
// divsqrt unit and holds each result until the consumer accepts it.
module fp_divsqrt_issue_ctrl #(
  parameter int unsigned FP_WIDTH   = 32,
  // Tag / rounding / status widths match the APU's WAPUTAG, NDSFLAGS_DIVSQRT, NUSFLAGS_DIVSQRT
  parameter int unsigned TAG_WIDTH  = 5,
  parameter int unsigned RND_WIDTH  = 3,
  parameter int unsigned STAT_WIDTH = 5,
  parameter int unsigned DEPTH      = 4
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  fp_divsqrt_issue_ctrl_if.slave io
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 2 * FP_WIDTH + 1 + TAG_WIDTH + RND_WIDTH;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                state_q, state_d;
  logic [ENT_W-1:0]      mem_q [DEPTH];
  logic [ENT_W-1:0]      mem_d [DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  res_valid_q, res_valid_d;
  logic [FP_WIDTH-1:0]   res_q, res_d;
  logic [STAT_WIDTH-1:0] stat_q, stat_d;
  logic [TAG_WIDTH-1:0]  rtag_q, rtag_d;

  logic push, issue, capture, ready;

  assign ready   = (count_q != CNT_W'(DEPTH));
  assign push    = io.req_valid_i & ready;
  // Issue only when the result slot is free or being freed this cycle
  assign issue   = (state_q == IDLE) & (count_q != '0) & io.unit_ready_i &
                   (~res_valid_q | io.res_ready_i);
  assign capture = (state_q == BUSY) & io.unit_valid_i;

  assign io.req_ready_o  = ready;
  assign io.unit_en_o    = issue;
  assign {io.unit_opa_o, io.unit_opb_o, io.unit_sqrt_o, io.unit_tag_o, io.unit_rnd_o} =
         mem_q[rptr_q];
  assign io.res_valid_o  = res_valid_q;
  assign io.res_o        = res_q;
  assign io.res_status_o = stat_q;
  assign io.res_tag_o    = rtag_q;
  assign io.count_o      = count_q;
  assign io.busy_o       = (count_q != '0) | (state_q == BUSY) | res_valid_q;

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    tag_d       = tag_q;
    res_valid_d = res_valid_q;
    res_d       = res_q;
    stat_d      = stat_q;
    rtag_d      = rtag_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(issue);

    if (push) begin
      mem_d[wptr_q] = {io.req_opa_i, io.req_opb_i, io.req_sqrt_i, io.req_tag_i, io.req_rnd_i};
      wptr_d        = wptr_q + PTR_W'(1);
    end

    if (res_valid_q & io.res_ready_i) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (issue) begin
          rptr_d  = rptr_q + PTR_W'(1);
          tag_d   = io.unit_tag_o;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (capture) begin
          res_valid_d = 1'b1;
          res_d       = io.unit_res_i;
          stat_d      = io.unit_status_i;
          rtag_d      = tag_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      tag_q       <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      stat_q      <= '0;
      rtag_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      tag_q       <= tag_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      stat_q      <= stat_d;
      rtag_q      <= rtag_d;
    end
  end
endmodule
